// File: rtl/vgacon_term_ctrl_if.sv
// Byte-stream, character-buffer and cursor signals of the terminal write sequencer.
// The slave modport is the sequencer; the master modport is the host/buffer side.
interface vgacon_term_ctrl_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic [2:0]        in_color;
    logic              in_ready;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [9:0]        buf_wdata;
    logic [ADDR_W-1:0] buf_raddr;
    logic [9:0]        buf_rdata;
    logic [1:0]        cursor_row;
    logic [3:0]        cursor_col;

    modport master (
        output in_valid, in_data, in_color, buf_rdata,
        input  in_ready, buf_we, buf_addr, buf_wdata, buf_raddr, cursor_row, cursor_col
    );

    modport slave (
        input  in_valid, in_data, in_color, buf_rdata,
        output in_ready, buf_we, buf_addr, buf_wdata, buf_raddr, cursor_row, cursor_col
    );
endinterface

// File: rtl/vgacon_term_ctrl.sv
// Terminal write sequencer: turns a byte stream into character-buffer cell writes,
// tracks the cursor and runs the multi-cycle scroll and clear sequences.
module vgacon_term_ctrl #(
    parameter int unsigned NUM_ROWS      = 3,
    parameter int unsigned NUM_COLS      = 10,
    parameter int unsigned ADDR_W        = 5,
    parameter logic [2:0]  DEFAULT_COLOR = 3'b010
) (
    input logic               clk,
    input logic               rst_n,
    vgacon_term_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] CopyLast  = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] CellLast  = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] RowStride = ADDR_W'(NUM_COLS);
    localparam logic [1:0]        LastRow   = 2'(NUM_ROWS - 1);
    localparam logic [3:0]        LastCol   = 4'(NUM_COLS - 1);
    localparam logic [9:0]        Blank     = {DEFAULT_COLOR, 7'h20};

    typedef enum logic [1:0] {StIdle, StScrollCopy, StScrollClear, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ctr_q, ctr_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        wdata_q, wdata_d;

    logic              printable;
    logic              advance_row;
    logic [ADDR_W-1:0] cur_addr;

    assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7e);
    assign cur_addr  = ADDR_W'(row_q) * RowStride + ADDR_W'(col_q);

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        row_d       = row_q;
        col_d       = col_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        advance_row = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (printable) begin
                        we_d    = 1'b1;
                        addr_d  = cur_addr;
                        wdata_d = {bus.in_color, bus.in_data[6:0]};
                        if (col_q == LastCol) begin
                            col_d       = 4'd0;
                            advance_row = 1'b1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else begin
                        case (bus.in_data)
                            8'h0a: begin
                                col_d       = 4'd0;
                                advance_row = 1'b1;
                            end
                            8'h0d: col_d = 4'd0;
                            8'h08: begin
                                if (col_q != 4'd0) begin
                                    col_d   = col_q - 4'd1;
                                    we_d    = 1'b1;
                                    addr_d  = cur_addr - ADDR_W'(1);
                                    wdata_d = Blank;
                                end
                            end
                            8'h0c: begin
                                state_d = StClear;
                                ctr_d   = '0;
                                row_d   = 2'd0;
                                col_d   = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                    // Newline past the bottom row scrolls; the cursor parks at the last row.
                    if (advance_row) begin
                        if (row_q == LastRow) begin
                            state_d = StScrollCopy;
                            ctr_d   = '0;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end
                end
            end
            StScrollCopy: begin
                we_d    = 1'b1;
                addr_d  = ctr_q;
                wdata_d = bus.buf_rdata;
                ctr_d   = ctr_q + ADDR_W'(1);
                if (ctr_q == CopyLast) state_d = StScrollClear;
            end
            StScrollClear, StClear: begin
                we_d    = 1'b1;
                addr_d  = ctr_q;
                wdata_d = Blank;
                if (ctr_q == CellLast) begin
                    state_d = StIdle;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ctr_q   <= '0;
            row_q   <= 2'd0;
            col_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 10'd0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Copy source runs one row ahead of the write address.
    assign bus.buf_raddr  = ctr_q + RowStride;
    assign bus.in_ready   = (state_q == StIdle);
    assign bus.buf_we     = we_q;
    assign bus.buf_addr   = addr_q;
    assign bus.buf_wdata  = wdata_q;
    assign bus.cursor_row = row_q;
    assign bus.cursor_col = col_q;
endmodule

// File: tb/tb_vgacon_term_ctrl.sv
// Bench for vgacon_term_ctrl: a behavioural RAM and a row/column text-screen model
// check every byte's writes, timing, cursor and resulting buffer contents.
module tb_vgacon_term_ctrl;
    localparam int unsigned NUM_ROWS = 3;
    localparam int unsigned NUM_COLS = 10;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CELLS    = NUM_ROWS * NUM_COLS;
    localparam logic [2:0]  DEF_COL  = 3'b010;
    localparam logic [9:0]  BLANK    = {DEF_COL, 7'h20};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vgacon_term_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    vgacon_term_ctrl #(
        .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .ADDR_W(ADDR_W), .DEFAULT_COLOR(DEF_COL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Character buffer RAM: combinational read, write captured mid-cycle.
    logic [9:0] mem [0:31];
    bit         seeded = 1'b0;
    int         cyc = 0;
    int         wr_addr_q[$];
    int         wr_cyc_q[$];
    assign bus.buf_rdata = mem[bus.buf_raddr];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 10'((i * 97 + 13) % 1024);
            seeded <= 1'b1;
        end else if (bus.buf_we === 1'b1) begin
            mem[bus.buf_addr] <= bus.buf_wdata;
            wr_addr_q.push_back(int'(bus.buf_addr));
            wr_cyc_q.push_back(cyc);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Screen model
    logic [9:0] mbuf [NUM_ROWS][NUM_COLS];
    int mrow, mcol;
    int exp_addr[$];
    int exp_busy;
    int exp_lead;

    task automatic model_newline();
        if (mrow < NUM_ROWS - 1) begin
            mrow++;
        end else begin
            for (int r = 0; r < NUM_ROWS - 1; r++)
                for (int c = 0; c < NUM_COLS; c++) mbuf[r][c] = mbuf[r + 1][c];
            for (int c = 0; c < NUM_COLS; c++) mbuf[NUM_ROWS - 1][c] = BLANK;
            for (int a = 0; a < CELLS; a++) exp_addr.push_back(a);
            exp_busy = CELLS;
        end
    endtask

    task automatic model_apply(input logic [7:0] d, input logic [2:0] c);
        exp_addr.delete();
        exp_busy = 0;
        exp_lead = 1;
        if (d >= 8'h20 && d <= 8'h7e) begin
            mbuf[mrow][mcol] = {c, d[6:0]};
            exp_addr.push_back(mrow * NUM_COLS + mcol);
            exp_lead = 0;
            if (mcol == NUM_COLS - 1) begin
                mcol = 0;
                model_newline();
            end else begin
                mcol++;
            end
        end else if (d == 8'h0a) begin
            mcol = 0;
            model_newline();
        end else if (d == 8'h0d) begin
            mcol = 0;
        end else if (d == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                mbuf[mrow][mcol] = BLANK;
                exp_addr.push_back(mrow * NUM_COLS + mcol);
                exp_lead = 0;
            end
        end else if (d == 8'h0c) begin
            for (int r = 0; r < NUM_ROWS; r++)
                for (int k = 0; k < NUM_COLS; k++) mbuf[r][k] = BLANK;
            mrow = 0;
            mcol = 0;
            for (int a = 0; a < CELLS; a++) exp_addr.push_back(a);
            exp_busy = CELLS;
        end
    endtask

    // Hold the byte until accepted; returns at #1 after the accepting edge.
    task automatic accept(input logic [7:0] d, input logic [2:0] c, output int acc);
        int w;
        w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_color = c;
        while (bus.in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready still %b after %0d cycles, required 1",
                     bus.in_ready, w);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic send_check(input logic [7:0] d, input logic [2:0] c, input string tag);
        int busy, acc, base, nwr, bad_i;
        model_apply(d, c);
        base = wr_addr_q.size();
        accept(d, c, acc);
        busy = 0;
        while (bus.in_ready !== 1'b1 && busy < 100) begin
            @(posedge clk);
            #1;
            busy++;
        end
        @(posedge clk);
        #1;
        nwr = wr_addr_q.size() - base;
        n_vec++;
        if (busy !== exp_busy) begin
            n_err++;
            $display("FAIL %s busy byte=%h: got %0d cycles, required %0d", tag, d, busy, exp_busy);
        end
        n_vec++;
        if (nwr !== exp_addr.size()) begin
            n_err++;
            $display("FAIL %s write_count byte=%h: got %0d, required %0d",
                     tag, d, nwr, exp_addr.size());
        end else begin
            bad_i = -1;
            for (int i = 0; i < nwr; i++)
                if (bad_i < 0 && (wr_addr_q[base + i] !== exp_addr[i] ||
                                  wr_cyc_q[base + i] !== acc + exp_lead + i)) bad_i = i;
            n_vec++;
            if (bad_i >= 0) begin
                n_err++;
                $display("FAIL %s write_seq byte=%h idx %0d: got addr %0d cyc %0d, required addr %0d cyc %0d",
                         tag, d, bad_i, wr_addr_q[base + bad_i], wr_cyc_q[base + bad_i],
                         exp_addr[bad_i], acc + exp_lead + bad_i);
            end
        end
        n_vec++;
        if (bus.cursor_row !== 2'(mrow) || bus.cursor_col !== 4'(mcol)) begin
            n_err++;
            $display("FAIL %s cursor byte=%h: got (%0d,%0d), required (%0d,%0d)",
                     tag, d, bus.cursor_row, bus.cursor_col, mrow, mcol);
        end
        bad_i = -1;
        for (int i = 0; i < CELLS; i++)
            if (bad_i < 0 && mem[i] !== mbuf[i / NUM_COLS][i % NUM_COLS]) bad_i = i;
        n_vec++;
        if (bad_i >= 0) begin
            n_err++;
            $display("FAIL %s buffer byte=%h cell %0d: got %h, required %h", tag, d, bad_i,
                     mem[bad_i], mbuf[bad_i / NUM_COLS][bad_i % NUM_COLS]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.buf_we !== 1'b0 || bus.buf_addr !== 5'd0 ||
            bus.buf_wdata !== 10'd0 || bus.cursor_row !== 2'd0 || bus.cursor_col !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b we=%b addr=%0d wd=%h cur=(%0d,%0d), required 1 0 0 000 (0,0)",
                     bus.in_ready, bus.buf_we, bus.buf_addr, bus.buf_wdata,
                     bus.cursor_row, bus.cursor_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_char();
        int acc;
        model_apply(8'h41, 3'b100);
        accept(8'h41, 3'b100, acc);
        n_vec++;
        if (bus.buf_we !== 1'b1 || bus.buf_addr !== 5'd0 || bus.buf_wdata !== 10'h241) begin
            n_err++;
            $display("FAIL single_write: got we=%b addr=%0d wd=%h, required 1 0 241",
                     bus.buf_we, bus.buf_addr, bus.buf_wdata);
        end
        n_vec++;
        if (bus.cursor_row !== 2'd0 || bus.cursor_col !== 4'd1) begin
            n_err++;
            $display("FAIL single_cursor: got (%0d,%0d), required (0,1)",
                     bus.cursor_row, bus.cursor_col);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.buf_we !== 1'b0) begin
            n_err++;
            $display("FAIL single_we_pulse: got we=%b in second cycle, required 0", bus.buf_we);
        end
    endtask

    task automatic test_line_wrap();
        for (int i = 0; i < 9; i++) send_check(8'($urandom_range(32, 126)), 3'($urandom), "wrap");
    endtask

    task automatic test_scroll();
        send_check(8'h0c, 3'b000, "scroll_pre_ff");
        for (int i = 0; i < 30; i++) send_check(8'h61 + 8'(i), 3'(i), "scroll");
    endtask

    task automatic test_back_to_back();
        int a0, a1, exp_wa, bad_i;
        model_apply(8'h0a, 3'b000);
        exp_wa = mrow * NUM_COLS + mcol;
        accept(8'h0a, 3'b000, a0);
        accept(8'h5a, 3'b001, a1);
        model_apply(8'h5a, 3'b001);
        n_vec++;
        if (a1 - a0 !== CELLS + 1) begin
            n_err++;
            $display("FAIL b2b_gap: got %0d cycles between accepts, required %0d", a1 - a0, CELLS + 1);
        end
        n_vec++;
        if (bus.buf_we !== 1'b1 || bus.buf_addr !== 5'(exp_wa) || bus.buf_wdata !== 10'h0da) begin
            n_err++;
            $display("FAIL b2b_write: got we=%b addr=%0d wd=%h, required 1 %0d 0da",
                     bus.buf_we, bus.buf_addr, bus.buf_wdata, exp_wa);
        end
        @(posedge clk);
        #1;
        bad_i = -1;
        for (int i = 0; i < CELLS; i++)
            if (bad_i < 0 && mem[i] !== mbuf[i / NUM_COLS][i % NUM_COLS]) bad_i = i;
        n_vec++;
        if (bad_i >= 0) begin
            n_err++;
            $display("FAIL b2b_buffer cell %0d: got %h, required %h", bad_i, mem[bad_i],
                     mbuf[bad_i / NUM_COLS][bad_i % NUM_COLS]);
        end
    endtask

    task automatic test_backspace();
        send_check(8'h0c, 3'b000, "bs_ff");
        send_check(8'h0a, 3'b000, "bs_lf");
        send_check(8'h08, 3'b000, "bs_col0");
        send_check(8'h78, 3'b011, "bs_x");
        send_check(8'h79, 3'b011, "bs_y");
        send_check(8'h7a, 3'b011, "bs_z");
        send_check(8'h08, 3'b000, "bs");
        n_vec++;
        if (bus.cursor_row !== 2'd1 || bus.cursor_col !== 4'd2 || mem[12] !== 10'h120) begin
            n_err++;
            $display("FAIL bs_cell12: got cur=(%0d,%0d) mem12=%h, required (1,2) 120",
                     bus.cursor_row, bus.cursor_col, mem[12]);
        end
    endtask

    task automatic test_clear_ignore();
        send_check(8'h51, 3'b110, "clr_q");
        send_check(8'h52, 3'b110, "clr_r");
        send_check(8'h0c, 3'b000, "clear");
        n_vec++;
        if (bus.cursor_row !== 2'd0 || bus.cursor_col !== 4'd0) begin
            n_err++;
            $display("FAIL clear_cursor: got (%0d,%0d), required (0,0)",
                     bus.cursor_row, bus.cursor_col);
        end
        send_check(8'h07, 3'b101, "ignore_07");
        send_check(8'h80, 3'b101, "ignore_80");
    endtask

    task automatic test_random();
        logic [7:0] d;
        int k;
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 19);
            if (k < 12)       d = 8'($urandom_range(32, 126));
            else if (k < 14)  d = 8'h0a;
            else if (k == 14) d = 8'h0d;
            else if (k < 17)  d = 8'h08;
            else if (k == 17) d = ($urandom_range(0, 3) == 0) ? 8'h0c : 8'h2e;
            else              d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7))
                                                               : 8'($urandom_range(127, 255));
            send_check(d, 3'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_scroll();
        int acc;
        send_check(8'h0c, 3'b000, "rst_ff");
        send_check(8'h0a, 3'b000, "rst_lf1");
        send_check(8'h0a, 3'b000, "rst_lf2");
        accept(8'h0a, 3'b000, acc);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.buf_we !== 1'b0 ||
            bus.cursor_row !== 2'd0 || bus.cursor_col !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid: got rdy=%b we=%b cur=(%0d,%0d), required 1 0 (0,0)",
                     bus.in_ready, bus.buf_we, bus.cursor_row, bus.cursor_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mrow = 0;
        mcol = 0;
        send_check(8'h0c, 3'b000, "post_rst_ff");
        send_check(8'h4b, 3'b111, "post_rst_k");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_color = 3'b000;
        for (int i = 0; i < CELLS; i++)
            mbuf[i / NUM_COLS][i % NUM_COLS] = 10'((i * 97 + 13) % 1024);
        mrow = 0;
        mcol = 0;
        test_reset();
        test_single_char();
        test_line_wrap();
        test_scroll();
        test_back_to_back();
        test_backspace();
        test_clear_ignore();
        test_random();
        test_reset_mid_scroll();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
